fetch_redirect_ctrl: RTL

Sequencing controller for the fetch-stage program counter. Arbitrates every PC redirect source (trap, branch misprediction correction, decode-resolved JALR) against hazard stalls, holds a redirect that arrives while the PC register is frozen, and issues it once the stall clears. It then masks the wrong-path instructions already in the fetch pipe for a fixed number of accepted cycles. It sits between the hazard unit, decode and execute on one side and the PC register/next-PC mux on the other.

---
 rtl/fetch_redirect_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC redirect sequencer: prioritises trap/mispredict/JALR redirects,
// holds a redirect across hazard stalls, then masks wrong-path fetches for a fixed window.
module fetch_redirect_ctrl #(
  parameter int size         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             trap_valid,
  input  logic [size-1:0]  trap_vector,
  input  logic             mispredict_valid,
  input  logic [size-1:0]  correct_pc,
  input  logic             jalr_valid,
  input  logic [size-1:0]  jalr_target,
  output logic             pc_we,
  output logic             redirect_valid,
  output logic [size-1:0]  redirect_pc,
  output logic             fetch_valid,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t            r_state;
  logic [size-1:0]   r_pend_pc;
  logic [1:0]        r_pend_pri;
  logic [3:0]        r_flush_cnt;
  logic [CNT_W-1:0]  r_count;

  logic              w_jalr_ok;
  logic              w_ev_valid;
  logic [1:0]        w_ev_pri;
  logic [size-1:0]   w_ev_pc;
  logic              w_ev_wins;
  logic [1:0]        w_best_pri;
  logic [size-1:0]   w_best_pc;
  logic              w_issue;
  logic [size-1:0]   w_issue_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Event selection; lower priority number wins, and the same-cycle event wins a tie with pending.
  always_comb begin
    w_jalr_ok  = jalr_valid & (r_state != FLUSH);
    w_ev_valid = trap_valid | mispredict_valid | w_jalr_ok;
    w_ev_pri   = 2'd2;
    w_ev_pc    = jalr_target;
    if (trap_valid) begin
      w_ev_pri = 2'd0;
      w_ev_pc  = trap_vector;
    end else if (mispredict_valid) begin
      w_ev_pri = 2'd1;
      w_ev_pc  = correct_pc;
    end
    w_ev_wins  = w_ev_valid & (w_ev_pri <= r_pend_pri);
    w_best_pri = w_ev_wins ? w_ev_pri : r_pend_pri;
    w_best_pc  = w_ev_wins ? w_ev_pc  : r_pend_pc;

    w_issue    = 1'b0;
    w_issue_pc = w_ev_pc;
    case (r_state)
      PENDING: begin
        w_issue    = ~stall;
        w_issue_pc = w_best_pc;
      end
      default: w_issue = w_ev_valid & ~stall;
    endcase
    w_issue = w_issue & ~reset;
  end

  assign pc_we          = ~stall & ~reset;
  assign redirect_valid = w_issue;
  assign redirect_pc    = w_issue ? w_issue_pc : '0;
  assign fetch_valid    = ~reset & (r_state == IDLE) & ~w_ev_valid;
  assign busy           = (r_state != IDLE);
  assign redirect_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend_pc   <= '0;
      r_pend_pri  <= 2'd3;
      r_flush_cnt <= 4'd0;
      r_count     <= '0;
    end else begin
      if (w_issue) r_count <= sat_inc(r_count);
      case (r_state)
        IDLE: begin
          if (w_ev_valid) begin
            if (stall) begin
              r_pend_pc  <= w_ev_pc;
              r_pend_pri <= w_ev_pri;
              r_state    <= PENDING;
            end else begin
              r_flush_cnt <= CNT_LOAD;
              r_state     <= FLUSH;
            end
          end
        end
        PENDING: begin
          if (!stall) begin
            r_flush_cnt <= CNT_LOAD;
            r_state     <= FLUSH;
          end else begin
            r_pend_pc  <= w_best_pc;
            r_pend_pri <= w_best_pri;
          end
        end
        FLUSH: begin
          // Only trap/mispredict reach here; a counter of zero still reloads on a new redirect.
          if (w_ev_valid) begin
            if (stall) begin
              r_pend_pc  <= w_ev_pc;
              r_pend_pri <= w_ev_pri;
              r_state    <= PENDING;
            end else begin
              r_flush_cnt <= CNT_LOAD;
            end
          end else if (!stall) begin
            if (r_flush_cnt == 4'd0) r_state <= IDLE;
            else r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
